hysteresis_saturating_counter_table: RTL

HYSTERESIS_SATURATING_COUNTER_TABLE -- requirements
Module: hysteresis_saturating_counter_table

---
 rtl/hysteresis_saturating_counter_table.sv | 84 ++++++++
 1 files changed

// File: rtl/hysteresis_saturating_counter_table.sv
// Table of independent saturating counters with a hysteresis jump across the
// midpoint, so that a single step across the threshold lands well inside the other half.
module hysteresis_saturating_counter_table #(
  parameter int DEPTH       = 16,
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 0,
  parameter int COERCIVITY  = 1,
  parameter bit READ_BYPASS = 1'b0,
  parameter int WIDTH       = $clog2(RANGE),
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   update_enable,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_increment,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [WIDTH-1:0]       read_count,
  output logic                   read_high
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(RANGE - 1);
  localparam logic [WIDTH-1:0] HALF_LOW  = WIDTH'(RANGE / 2 - 1);
  localparam logic [WIDTH-1:0] HALF_HIGH = WIDTH'(RANGE / 2);
  localparam logic [WIDTH-1:0] JUMP_HIGH = WIDTH'(RANGE / 2 + COERCIVITY);
  localparam logic [WIDTH-1:0] JUMP_LOW  = WIDTH'(RANGE / 2 - 1 - COERCIVITY);
  localparam logic [WIDTH-1:0] INIT      = WIDTH'(RESET_VALUE);
  localparam logic [INDEX_WIDTH:0] DEPTH_X = (INDEX_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic             update_valid;
  logic             read_valid;

  // Saturate at both ends; crossing the midpoint skips COERCIVITY values.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic inc);
    logic [WIDTH-1:0] r;
    r = v;
    if (inc) begin
      if (v == MAX_COUNT)     r = v;
      else if (v == HALF_LOW) r = JUMP_HIGH;
      else                    r = v + WIDTH'(1);
    end else begin
      if (v == '0)             r = v;
      else if (v == HALF_HIGH) r = JUMP_LOW;
      else                     r = v - WIDTH'(1);
    end
    return r;
  endfunction

  // Indices past DEPTH only exist when DEPTH is not a power of two.
  assign update_valid = ({1'b0, update_index} < DEPTH_X);
  assign read_valid   = ({1'b0, read_index} < DEPTH_X);

  // NOTE: every entry is reset, not just the control state, because the counts
  // themselves must read RESET_VALUE while resetn is low; the table is small
  // enough to be flops rather than a RAM macro.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= INIT;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= INIT;
    end else if (update_enable && update_valid) begin
      // NOTE: non-blocking so every entry sees pre-edge values regardless of order.
      entries[update_index] <= step(entries[update_index], update_increment);
    end
  end

  // NOTE: read_count gets a default first so no path through the branches infers a latch.
  always_comb begin
    read_count = '0;
    if (read_valid) begin
      if (READ_BYPASS && clear)
        read_count = INIT;
      else if (READ_BYPASS && update_enable && update_valid && (update_index == read_index))
        read_count = step(entries[read_index], update_increment);
      else
        read_count = entries[read_index];
    end
  end

  assign read_high = (read_count >= HALF_HIGH);

endmodule
